// File: rtl/ram_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; the default build gives data fixed priority.
module ram_arbiter #(
    parameter int unsigned MEM_SIZE   = 16384,
    parameter logic [31:0] START_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_rdata,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [3:0]  d_req_wstrb,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state;
    logic [31:0] hold_addr;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic [31:0] sel_addr;
    logic        prefer_d;
    logic        grant_d;
    logic        grant_i;
    logic        d_fault;
    logic        i_fault;
    logic        d_full;
    logic        d_none;

`ifdef RAM_ARB_RR_EN
    logic last_d;
    assign prefer_d = !last_d;
`else
    assign prefer_d = 1'b1;
`endif

    function automatic logic is_fault(input logic [31:0] a);
        logic [32:0] lim;
        lim = {1'b0, START_ADDR} + 33'(MEM_SIZE);
        return (a[1:0] != 2'b00) || (a < START_ADDR) || ({1'b0, a} >= lim);
    endfunction

    assign grant_d = (state == IDLE) && d_req_valid && (!i_req_valid || prefer_d);
    assign grant_i = (state == IDLE) && i_req_valid && !grant_d;
    assign d_req_ready = grant_d;
    assign i_req_ready = grant_i;

    assign d_fault  = is_fault(d_req_addr);
    assign i_fault  = is_fault(i_req_addr);
    assign d_full   = (d_req_wstrb == 4'hF);
    assign d_none   = (d_req_wstrb == 4'h0);
    assign sel_addr = grant_d ? d_req_addr : i_req_addr;

    always_comb begin
        merged = ram_rd;
        for (int n = 0; n < 4; n++) begin
            if (d_req_wstrb[n]) merged[8*n +: 8] = d_req_wdata[8*n +: 8];
        end
    end

    // RMW_WR owns the RAM port; otherwise it follows the granted request
    always_comb begin
        ram_addr = {sel_addr[31:2], 2'b00};
        ram_wd   = d_req_wdata;
        ram_we   = grant_d && d_req_we && !d_fault && d_full;
        if (state == RMW_WR) begin
            ram_addr = hold_addr;
            ram_wd   = merge_q;
            ram_we   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold_addr   <= 32'h0;
            merge_q     <= 32'h0;
            i_rsp_valid <= 1'b0;
            i_rsp_err   <= 1'b0;
            i_rsp_rdata <= 32'h0;
            d_rsp_valid <= 1'b0;
            d_rsp_err   <= 1'b0;
            d_rsp_rdata <= 32'h0;
`ifdef RAM_ARB_RR_EN
            last_d      <= 1'b0;
`endif
        end else begin
            i_rsp_valid <= 1'b0;
            i_rsp_err   <= 1'b0;
            i_rsp_rdata <= 32'h0;
            d_rsp_valid <= 1'b0;
            d_rsp_err   <= 1'b0;
            d_rsp_rdata <= 32'h0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        grant_d: begin
`ifdef RAM_ARB_RR_EN
                            last_d <= 1'b1;
`endif
                            if (d_fault) begin
                                d_rsp_valid <= 1'b1;
                                d_rsp_err   <= 1'b1;
                            end else if (!d_req_we) begin
                                d_rsp_valid <= 1'b1;
                                d_rsp_rdata <= ram_rd;
                            end else if (d_full || d_none) begin
                                d_rsp_valid <= 1'b1;
                            end else begin
                                hold_addr <= {d_req_addr[31:2], 2'b00};
                                merge_q   <= merged;
                                state     <= RMW_WR;
                            end
                        end
                        grant_i: begin
`ifdef RAM_ARB_RR_EN
                            last_d <= 1'b0;
`endif
                            i_rsp_valid <= 1'b1;
                            i_rsp_err   <= i_fault;
                            i_rsp_rdata <= i_fault ? 32'h0 : ram_rd;
                        end
                        default: ;
                    endcase
                end
                RMW_WR: begin
                    d_rsp_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 4 KiB-word RAM.
// Expected arbitration order follows RAM_ARB_RR_EN when defined.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [3:0]  d_req_wstrb;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] off;

    always #5 clk = ~clk;

    assign off    = ram_addr - 32'h8000_0000;
    assign ram_rd = (off < 32'd16384) ? mem[off[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we && off < 32'd16384) mem[off[13:2]] <= ram_wd;
    end

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_req_addr(i_req_addr), .i_rsp_valid(i_rsp_valid),
        .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_err(d_rsp_err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    task automatic test_reset;
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_we = 1'b0;
        d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err, ram_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err, ram_we});
        end
        checks++;
        if (i_rsp_rdata !== 32'h0 || d_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h/%h want 0/0", i_rsp_rdata, d_rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic data_op(input logic [31:0] a, input logic we,
                           input logic [3:0] s, input logic [31:0] wd);
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = a; d_req_we = we;
        d_req_wstrb = s; d_req_wdata = wd;
        #1;
        checks++;
        if (d_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL d_ready addr %h got %b want 1", a, d_req_ready);
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
    endtask

    task automatic test_fetch;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0000;
        #1;
        checks++;
        if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ready got i%b d%b want i1 d0", i_req_ready, d_req_ready);
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        checks++;
        if (i_rsp_valid !== 1'b1 || i_rsp_rdata !== 32'h0500_006F || i_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp got v%b %h e%b want v1 0500006f e0",
                     i_rsp_valid, i_rsp_rdata, i_rsp_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (i_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse got %b want 0", i_rsp_valid);
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0004; d_req_we = 1'b1;
        d_req_wstrb = 4'hF; d_req_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_wd !== 32'h1234_5678 || ram_addr !== 32'h8000_0004) begin
            errors++;
            $display("FAIL wr_port got we%b %h @%h want we1 12345678 @80000004",
                     ram_we, ram_wd, ram_addr);
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h0 || d_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp got v%b %h e%b want v1 0 e0",
                     d_rsp_valid, d_rsp_rdata, d_rsp_err);
        end
        data_op(32'h8000_0004, 1'b0, 4'h0, 32'h0);
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_back got v%b %h want v1 12345678", d_rsp_valid, d_rsp_rdata);
        end
        // zero strobe: no RAM write, still a response
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0004; d_req_we = 1'b1;
        d_req_wstrb = 4'h0; d_req_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wstrb0_we got %b want 0", ram_we);
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        checks++;
        if (d_rsp_valid !== 1'b1 || mem[1] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wstrb0_rsp got v%b mem %h want v1 12345678", d_rsp_valid, mem[1]);
        end
    endtask

    task automatic test_rmw;
        data_op(32'h8000_0008, 1'b1, 4'b0010, 32'h0000_1100);
        checks++;
        if (d_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_early_rsp got %b want 0", d_rsp_valid);
        end
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0000;
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0004; d_req_we = 1'b0;
        #1;
        checks++;
        if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmw_ready got i%b d%b want 0 0", i_req_ready, d_req_ready);
        end
        checks++;
        if (ram_we !== 1'b1 || ram_wd !== 32'hAABB_11DD || ram_addr !== 32'h8000_0008) begin
            errors++;
            $display("FAIL rmw_port got we%b %h @%h want we1 aabb11dd @80000008",
                     ram_we, ram_wd, ram_addr);
        end
        d_req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rmw_rsp got v%b e%b want v1 e0", d_rsp_valid, d_rsp_err);
        end
        checks++;
        if (i_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmw_waiter_ready got %b want 1", i_req_ready);
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        checks++;
        if (i_rsp_valid !== 1'b1 || i_rsp_rdata !== 32'h0500_006F) begin
            errors++;
            $display("FAIL rmw_waiter_rsp got v%b %h want v1 0500006f", i_rsp_valid, i_rsp_rdata);
        end
        data_op(32'h8000_0008, 1'b0, 4'h0, 32'h0);
        checks++;
        if (d_rsp_rdata !== 32'hAABB_11DD) begin
            errors++;
            $display("FAIL rmw_readback got %h want aabb11dd", d_rsp_rdata);
        end
    endtask

    task automatic test_faults;
        logic [31:0] bad [3];
        bad[0] = 32'h7FFF_FFFC;
        bad[1] = 32'h8000_4000;
        bad[2] = 32'h8000_0002;
        for (int k = 0; k < 3; k++) begin
            data_op(bad[k], 1'b0, 4'h0, 32'h0);
            checks++;
            if (d_rsp_valid !== 1'b1 || d_rsp_err !== 1'b1 || d_rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL fault_rd %h got v%b e%b %h want v1 e1 0",
                         bad[k], d_rsp_valid, d_rsp_err, d_rsp_rdata);
            end
        end
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = 32'h8000_0002; d_req_we = 1'b1;
        d_req_wstrb = 4'hF; d_req_wdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL fault_wr_we got %b want 0", ram_we);
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        checks++;
        if (d_rsp_err !== 1'b1 || mem[0] !== 32'h0500_006F) begin
            errors++;
            $display("FAIL fault_wr got e%b mem0 %h want e1 0500006f", d_rsp_err, mem[0]);
        end
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h8000_4000;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        checks++;
        if (i_rsp_valid !== 1'b1 || i_rsp_err !== 1'b1 || i_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fault_fetch got v%b e%b %h want v1 e1 0",
                     i_rsp_valid, i_rsp_err, i_rsp_rdata);
        end
    endtask

    task automatic test_arb;
        logic [3:0] exp_d;
`ifdef RAM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        // a fetch first so a round-robin pointer now favours data
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0000;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_req_valid = 1'b1; i_req_addr = 32'h8000_0000;
            d_req_valid = 1'b1; d_req_addr = 32'h8000_0004; d_req_we = 1'b0;
            #1;
            checks++;
            if (d_req_ready !== exp_d[c] || i_req_ready !== !exp_d[c]) begin
                errors++;
                $display("FAIL arb_cycle%0d got d%b i%b want d%b i%b",
                         c, d_req_ready, i_req_ready, exp_d[c], !exp_d[c]);
            end
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_rst_rmw;
        data_op(32'h8000_000C, 1'b1, 4'b0001, 32'h0000_00FF);
        checks++;
        if (ram_we !== 1'b1) begin
            errors++;
            $display("FAIL rstrmw_enter got we%b want 1", ram_we);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rstrmw_we got %b want 0", ram_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem[3] !== 32'h1122_3344 || d_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstrmw_abort got mem %h v%b want 11223344 v0", mem[3], d_rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (d_rsp_valid !== 1'b0 || mem[3] !== 32'h1122_3344) begin
            errors++;
            $display("FAIL rstrmw_after got v%b mem %h want v0 11223344", d_rsp_valid, mem[3]);
        end
        data_op(32'h8000_000C, 1'b0, 4'h0, 32'h0);
        checks++;
        if (d_rsp_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL rstrmw_read got %h want 11223344", d_rsp_rdata);
        end
    endtask

    initial begin
        for (int w = 0; w < 4096; w++) mem[w] = 32'h0;
        mem[0] = 32'h0500_006F;
        mem[2] = 32'hAABB_CCDD;
        mem[3] = 32'h1122_3344;
        test_reset();
        test_fetch();
        test_write_read();
        test_rmw();
        test_faults();
        test_arb();
        test_rst_rmw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
